windowing_ctrl: RTL
===================

// Module: windowing_ctrl
// PURPOSE
//  Frame sequencer for the windowing multiplier (17b sample x 4b coefficient -> 21b product, 1-clk registered).
//  - Accepts a frame of N_SAMPLES samples over a valid/ready handshake.
//  - Addresses the external window-coefficient ROM and pairs each sample with its coefficient.
//  - Drives the multiplier's enable and operands, then tags each product with valid/last.
//  - Sits between the pre-processing stage and the FFT input buffer.
// PARAMETERS
//  N_SAMPLES  256  samples per frame; even, >= 4
//  DATA_W     17   sample width
//  COEF_W     4    coefficient width (unsigned)
//  PROD_W     21   product width
//  AW         $clog2(N_SAMPLES)  coefficient address width (derived, localparam)
// PORTS
//  clk         in   1       rising-edge clock
//  rst         in   1       synchronous active-high reset
//  start       in   1       one-clock pulse; begins a frame when idle
//  s_valid     in   1       input sample valid
//  s_ready     out  1       controller accepts a sample this cycle
//  s_data      in   DATA_W  input sample
//  coef_addr   out  AW      coefficient ROM address
//  coef_data   in   COEF_W  ROM data; valid one clock after coef_addr
//  win_enable  out  1       multiplier enable; its output clears while low
//  win_in1     out  DATA_W  multiplier operand 1 (sample)
//  win_in2     out  COEF_W  multiplier operand 2 (coefficient)
//  win_out     in   PROD_W  multiplier registered product
//  m_valid     out  1       product valid; downstream always accepts
//  m_data      out  PROD_W  product, equal to win_out
//  m_last      out  1       with m_valid, marks the frame's final product
//  busy        out  1       state != IDLE
//  frame_done  out  1       one-clock pulse after the last product
// BEHAVIOUR
//  Reset
//   - All outputs are 0; state = IDLE; index = 0.
//   - Reset mid-frame discards in-flight samples; no m_valid or frame_done is produced for them.
//  FSM: IDLE -> RUN -> DRAIN -> IDLE
//   - IDLE: on start, go to RUN. Otherwise stay.
//   - RUN: s_ready = 1. Each accept (s_valid & s_ready) increments index. Accepting at index N_SAMPLES-1 goes to DRAIN.
//   - DRAIN: s_ready = 0. After 2 clocks, pulse frame_done and return to IDLE.
//   - start while busy is ignored.
//  Pipeline (sample accepted in cycle t)
//   - t: coef_addr = f(index); the sample is captured into an operand-stage register at the end of t.
//   - t+1: win_in1 = captured sample; win_in2 = coef_data.
//   - t+2: m_valid = 1; m_data = win_out.
//   - Stalls are bubbles: m_valid is 0 for cycles with no accept. Products are never reordered.
//  Multiplier control
//   - win_enable = 1 in RUN and DRAIN, 0 in IDLE.
//   - Operands hold their last values across bubbles.
//  m_last
//   - Asserts with the m_valid of the sample accepted at index N_SAMPLES-1.
//   - frame_done pulses the clock after m_last.
//  Back-to-back frames
//   - start may arrive in the same cycle as frame_done; RUN begins the next cycle.
//  Arithmetic
//   - No arithmetic in this block.
//   - The multiplier returns 0 when the sample is 0 or the coefficient is 0; the controller forwards that unchanged.
// CONFIGURATION
//  Macro WINCTRL_MIRROR_EN (symmetric window)
//   - Defined: f(index) = index for index < N_SAMPLES/2, else N_SAMPLES-1-index. The ROM holds only the first half.
//   - Not defined: f(index) = index (full-length ROM).
//   - coef_addr stays AW bits wide in both builds.
// STRUCTURE
//  Package windowing_pkg
//   - Width constants: DATA_W, COEF_W, PROD_W.
//   - State typedef: IDLE / RUN / DRAIN.
//  Sub-module windowing_ctrl_addr_gen
//   - Combinational index -> coef_addr mapping.
//   - Contains the WINCTRL_MIRROR_EN folding.
//  The multiplier is instantiated by the parent, not inside this block.
// TESTING
//  1. Reset during RUN at index 10 -> next cycle busy = 0, s_ready = 0, m_valid = 0, index = 0; no frame_done.
//  2. N_SAMPLES = 8; start, then 8 samples of 17'h00010 on consecutive cycles, ROM = i+1 -> m_data = 16*(i+1).
//     m_valid in cycles 3..10 after start+1; m_last with the 8th product; frame_done one cycle later.
//  3. s_valid toggling 1,0,1,0 -> m_valid gaps mirror the input gaps exactly, each 2 cycles after its accept.
//  4. WINCTRL_MIRROR_EN, N_SAMPLES = 8 -> coef_addr sequence 0,1,2,3,3,2,1,0.
//     Without the macro -> 0..7.
//  5. Sample 0 or coefficient 0 -> m_valid = 1 with m_data = 0.
//     start pulsed mid-frame -> ignored; frame length unchanged.
//  6. start in the frame_done cycle -> second frame runs with no idle gap; index restarts at 0.

Source files
------------

// File: rtl/windowing_pkg.sv
// Shared widths and FSM state type for the windowing multiplier frame sequencer.
package windowing_pkg;

  localparam int DATA_W = 17;
  localparam int COEF_W = 4;
  localparam int PROD_W = 21;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/windowing_ctrl_addr_gen.sv
// Sample index to coefficient ROM address mapping.
// WINCTRL_MIRROR_EN folds the second half of the frame onto a half-length ROM.
module windowing_ctrl_addr_gen #(
  parameter int N_SAMPLES = 256
) (
  input  logic [$clog2(N_SAMPLES)-1:0] index,
  output logic [$clog2(N_SAMPLES)-1:0] coef_addr
);

  localparam int AW = $clog2(N_SAMPLES);
  localparam logic [AW-1:0] HALF_IDX = AW'(N_SAMPLES / 2);
  localparam logic [AW-1:0] LAST_IDX = AW'(N_SAMPLES - 1);

  // Index to address mapping (identity or mirrored).
  always_comb begin
    coef_addr = index;
`ifdef WINCTRL_MIRROR_EN
    if (index >= HALF_IDX) begin
      coef_addr = LAST_IDX - index;
    end else begin
      coef_addr = index;
    end
`else
    if (index > LAST_IDX) begin
      coef_addr = LAST_IDX;
    end else begin
      coef_addr = index;
    end
`endif
  end

endmodule

// File: rtl/windowing_ctrl.sv
// Frame sequencer feeding the external windowing multiplier and tagging its products.
// Optional symmetric-window addressing via WINCTRL_MIRROR_EN (see windowing_ctrl_addr_gen).
module windowing_ctrl
  import windowing_pkg::*;
#(
  parameter int N_SAMPLES = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_W-1:0]             s_data,
  output logic [$clog2(N_SAMPLES)-1:0]  coef_addr,
  input  logic [COEF_W-1:0]             coef_data,
  output logic                          win_enable,
  output logic [DATA_W-1:0]             win_in1,
  output logic [COEF_W-1:0]             win_in2,
  input  logic [PROD_W-1:0]             win_out,
  output logic                          m_valid,
  output logic [PROD_W-1:0]             m_data,
  output logic                          m_last,
  output logic                          busy,
  output logic                          frame_done
);

  localparam int AW = $clog2(N_SAMPLES);
  localparam logic [AW-1:0] LAST_IDX = AW'(N_SAMPLES - 1);

  state_e              state_q, state_d;
  logic [AW-1:0]       index_q, index_d;
  logic                drain_q, drain_d;
  logic                stage_vld_q, stage_vld_d;
  logic                stage_last_q, stage_last_d;
  logic [DATA_W-1:0]   win_in1_q, win_in1_d;
  logic [COEF_W-1:0]   coef_hold_q, coef_hold_d;
  logic                m_valid_q, m_valid_d;
  logic                m_last_q, m_last_d;
  logic                s_ready_q, s_ready_d;
  logic                busy_q, busy_d;
  logic                win_enable_q, win_enable_d;
  logic                frame_done_q, frame_done_d;
  logic                accept_s;
  logic                last_accept_s;

  windowing_ctrl_addr_gen #(.N_SAMPLES(N_SAMPLES)) u_addr_gen (
    .index     (index_q),
    .coef_addr (coef_addr)
  );

  assign accept_s      = s_valid & s_ready_q;
  assign last_accept_s = accept_s & (index_q == LAST_IDX);

  // Next-state, index and pipeline tag computation.
  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    drain_d      = drain_q;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        index_d = '0;
        drain_d = 1'b0;
        if (start) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (last_accept_s) begin
          state_d = DRAIN;
          index_d = '0;
          drain_d = 1'b0;
        end else if (accept_s) begin
          index_d = index_q + AW'(1);
        end else begin
          index_d = index_q;
        end
      end
      DRAIN: begin
        // Two drain clocks cover the operand stage and the multiplier register.
        if (drain_q) begin
          state_d      = IDLE;
          drain_d      = 1'b0;
          frame_done_d = 1'b1;
        end else begin
          drain_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        index_d = '0;
        drain_d = 1'b0;
      end
    endcase

    stage_vld_d  = accept_s;
    stage_last_d = last_accept_s;
    win_in1_d    = accept_s ? s_data : win_in1_q;
    coef_hold_d  = stage_vld_q ? coef_data : coef_hold_q;
    m_valid_d    = stage_vld_q;
    m_last_d     = stage_last_q;
    s_ready_d    = (state_d == RUN);
    busy_d       = (state_d != IDLE);
    win_enable_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      index_q      <= '0;
      drain_q      <= 1'b0;
      stage_vld_q  <= 1'b0;
      stage_last_q <= 1'b0;
      win_in1_q    <= '0;
      coef_hold_q  <= '0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      s_ready_q    <= 1'b0;
      busy_q       <= 1'b0;
      win_enable_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      drain_q      <= drain_d;
      stage_vld_q  <= stage_vld_d;
      stage_last_q <= stage_last_d;
      win_in1_q    <= win_in1_d;
      coef_hold_q  <= coef_hold_d;
      m_valid_q    <= m_valid_d;
      m_last_q     <= m_last_d;
      s_ready_q    <= s_ready_d;
      busy_q       <= busy_d;
      win_enable_q <= win_enable_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Coefficient is live from the ROM in the operand cycle, then held across bubbles.
  assign win_in2    = stage_vld_q ? coef_data : coef_hold_q;
  assign win_in1    = win_in1_q;
  assign win_enable = win_enable_q;
  assign s_ready    = s_ready_q;
  assign busy       = busy_q;
  assign m_valid    = m_valid_q;
  assign m_last     = m_last_q;
  assign m_data     = win_out;
  assign frame_done = frame_done_q;

endmodule
